// File: rtl/axi_traffic_gen_chk.sv
// axi_traffic_gen_chk
//   AXI4 master traffic generator and checker. A start pulse makes it write
//   NUM_BURSTS INCR bursts of an incrementing pattern from BASE_ADDR. It then
//   reads the same bursts back and compares every beat. Only one transaction
//   is outstanding at a time, and AW is always complete before W begins.
//
// Ports
//   aclk, aresetn        clock and synchronous active-low reset
//   start                run request, accepted only in IDLE or DONE
//   busy, done           run in progress / run finished
//   error, err_count     sticky error flag and saturating error count
//   m_axi_aw*, m_axi_w*, m_axi_b*   write channels (master side)
//   m_axi_ar*, m_axi_r*             read channels (master side)
//
// Optional feature (macro TGC_PERF_CNT_EN):
//   adds wr_cycles / rd_cycles, the saturating cycle counts spent in the
//   write (AW..B) and read (AR..R) phases of the current run.
module axi_traffic_gen_chk #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 64,
  parameter int unsigned       ID_W         = 4,
  parameter int unsigned       BURST_LEN    = 16,
  parameter int unsigned       NUM_BURSTS   = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter logic [31:0]       PATTERN_SEED = 32'h0
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         err_count,
`ifdef TGC_PERF_CNT_EN
  output logic [31:0]         wr_cycles,
  output logic [31:0]         rd_cycles,
`endif
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  localparam int unsigned       LANES      = DATA_W / 32;
  localparam int unsigned       AXSIZE     = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN * (DATA_W / 8));
  localparam logic [8:0]        LAST_BEAT  = 9'(BURST_LEN - 1);
  localparam logic [15:0]       LAST_BURST = 16'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  state_t            state, state_next;
  logic [15:0]       burst;
  logic [8:0]        beat;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       pat;

  logic              start_acc, w_hs, b_hs, r_hs, last_beat, last_burst;
  logic              b_err, r_resp_err, r_data_err, r_last_err;
  logic [1:0]        err_inc;
  logic [16:0]       err_sum;
  logic [15:0]       err_next;
  logic [DATA_W-1:0] pat_data;

  assign last_beat  = (beat == LAST_BEAT);
  assign last_burst = (burst == LAST_BURST);
  assign start_acc  = start && (state == S_IDLE || state == S_DONE);
  assign w_hs       = (state == S_W) && m_axi_wready;
  assign b_hs       = (state == S_B) && m_axi_bvalid;
  assign r_hs       = (state == S_R) && m_axi_rvalid;
  assign pat_data   = {LANES{pat}};

  // The beat counter, not RLAST, decides when a read burst ends, so a bad
  // RLAST is counted as an error but never shortens or stretches the run.
  assign b_err      = b_hs && (m_axi_bresp != 2'b00);
  assign r_resp_err = r_hs && (m_axi_rresp != 2'b00);
  assign r_data_err = r_hs && (m_axi_rdata != pat_data);
  assign r_last_err = r_hs && (m_axi_rlast != last_beat);
  assign err_inc    = 2'(b_err) + 2'(r_resp_err) + 2'(r_data_err) + 2'(r_last_err);
  assign err_sum    = {1'b0, err_count} + {15'd0, err_inc};
  assign err_next   = err_sum[16] ? '1 : err_sum[15:0];

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE: if (start)              state_next = S_AW;
      S_AW:           if (m_axi_awready)      state_next = S_W;
      S_W:            if (w_hs && last_beat)  state_next = S_B;
      S_B:            if (b_hs)               state_next = last_burst ? S_AR : S_AW;
      S_AR:           if (m_axi_arready)      state_next = S_R;
      S_R:            if (r_hs && last_beat)  state_next = last_burst ? S_DONE : S_AR;
      default:                                state_next = S_IDLE;
    endcase
  end

  always_comb begin
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (state)
      S_AW:    m_axi_awvalid = 1'b1;
      S_W:     m_axi_wvalid  = 1'b1;
      S_B:     m_axi_bready  = 1'b1;
      S_AR:    m_axi_arvalid = 1'b1;
      S_R:     m_axi_rready  = 1'b1;
      S_DONE:  begin busy = 1'b0; done = 1'b1; end
      default: busy = 1'b0;
    endcase
  end

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr;
  assign m_axi_awlen   = 8'(BURST_LEN - 1);
  assign m_axi_awsize  = 3'(AXSIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_wdata   = pat_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = last_beat;
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = addr;
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'(AXSIZE);
  assign m_axi_arburst = 2'b01;

  // addr and pat are shared by both phases: they rewind to BASE_ADDR and
  // PATTERN_SEED on the final write response so the read phase replays them.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      burst     <= '0;
      beat      <= '0;
      addr      <= '0;
      pat       <= '0;
      error     <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_next;
      if (start_acc) begin
        burst     <= '0;
        beat      <= '0;
        addr      <= BASE_ADDR;
        pat       <= PATTERN_SEED;
        error     <= 1'b0;
        err_count <= '0;
      end else begin
        if (w_hs || r_hs) begin
          pat  <= pat + 32'd1;
          beat <= last_beat ? '0 : beat + 9'd1;
        end
        if (b_hs) begin
          if (last_burst) begin
            burst <= '0;
            addr  <= BASE_ADDR;
            pat   <= PATTERN_SEED;
          end else begin
            burst <= burst + 16'd1;
            addr  <= addr + BURST_STEP;
          end
        end
        if (r_hs && last_beat && !last_burst) begin
          burst <= burst + 16'd1;
          addr  <= addr + BURST_STEP;
        end
        if (err_inc != 2'd0) begin
          error     <= 1'b1;
          err_count <= err_next;
        end
      end
    end
  end

`ifdef TGC_PERF_CNT_EN
  always_ff @(posedge aclk) begin
    if (!aresetn || start_acc) begin
      wr_cycles <= '0;
      rd_cycles <= '0;
    end else begin
      if ((state == S_AW || state == S_W || state == S_B) && wr_cycles != '1)
        wr_cycles <= wr_cycles + 32'd1;
      if ((state == S_AR || state == S_R) && rd_cycles != '1)
        rd_cycles <= rd_cycles + 32'd1;
    end
  end
`endif

endmodule
